packet_demux: RTL
=================

// Module: packet_demux
// PURPOSE
//  Input stage of the router. Parses a byte-serial packet stream and forwards each
//  packet unchanged to one of three output channels (ch0..ch2): the first channel
//  whose configured 2-bit address matches the header's destination field.
//  Sits directly downstream of the config register block and consumes its ch0_addr,
//  ch1_addr, ch2_addr and crc_en outputs.
//  Packets matching no channel are consumed and dropped.
// PARAMETERS
//  MAX_LEN   63  largest legal payload length; header length > MAX_LEN -> packet dropped
// PORTS
//  clk        in   1  clock, all flops rising edge
//  rst_n      in   1  asynchronous active-low reset
//  din        in   8  packet byte
//  din_en     in   1  din valid; byte accepted on every cycle din_en=1 (gaps allowed)
//  ch0_addr   in   2  channel 0 address (from config regs)
//  ch1_addr   in   2  channel 1 address
//  ch2_addr   in   2  channel 2 address
//  crc_en     in   1  packets carry trailing CRC byte
//  ch0_dout   out  8  channel 0 byte      | ch0_valid  out 1  ch0_dout valid
//  ch1_dout   out  8  channel 1 byte      | ch1_valid  out 1  ch1_dout valid
//  ch2_dout   out  8  channel 2 byte      | ch2_valid  out 1  ch2_dout valid
//  busy       out  1  packet in progress (state != IDLE)
//  crc_err    out  1  1-cycle pulse: CRC mismatch
//  drop       out  1  1-cycle pulse: header accepted for a dropped packet
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, byte counter=0, running CRC=0.
//  - Packet format: header {len[7:2], dest[1:0]}, then len payload bytes (0..63),
//    then 1 CRC byte when crc_en. CRC = XOR of header and all payload bytes.
//  - Header cycle: dest, ch*_addr and crc_en latched; later config changes
//    do not affect the packet in flight. Match priority ch0 > ch1 > ch2.
//  - FSM: IDLE -> (din_en) header accepted: match & len<=MAX_LEN -> PAYLOAD,
//    else DROP. len=0 -> CRC (crc_en) or IDLE.
//    PAYLOAD -> after len accepted bytes -> CRC (crc_en) or IDLE.
//    CRC -> after 1 accepted byte -> IDLE.
//    DROP -> consumes len payload bytes (+CRC if crc_en) without output -> IDLE.
//  - Forwarding: every accepted byte of a routed packet (header, payload, CRC)
//    appears on chN_dout with chN_valid=1 exactly 1 cycle after acceptance.
//    Non-selected channels: valid=0, dout held.
//    Accepted bytes of a dropped packet raise no valid.
//  - din_en=0: no state/counter change, all valids 0 next cycle.
//  - Back-to-back: header of next packet may arrive the cycle after the last byte.
//  - drop pulses 1 cycle after the dropped header is accepted.
//  - busy: 1 from the cycle after header acceptance until return to IDLE.
//  - Reset mid-packet: immediate return to IDLE, partial packet discarded.
//  - Byte counter 6 bits; no wrap since len<=63.
// CONFIGURATION
//  CRC_CHECK_EN defined: running XOR compared with the CRC byte.
//    crc_err pulses in the same cycle the CRC byte is valid on the output.
//    No pulse for dropped packets. The CRC byte is still forwarded.
//  CRC_CHECK_EN undefined: no XOR logic; crc_err tied 0.
//    The CRC byte is framed and forwarded unchecked.
// TESTING
//  1 cfg ch1_addr=1, crc_en=0; send 09,A5,3C
//    -> ch1_valid for 3 cycles with 09,A5,3C, each 1 cycle late; ch0/ch2 silent.
//  2 crc_en=1, CRC_CHECK_EN; send 09,A5,3C,90 -> 4 bytes on ch1, crc_err=0.
//    Repeat with last byte 91 -> crc_err pulse aligned with the 4th ch1 byte.
//  3 ch0=ch2=2, ch1=0; send header 0A,11 -> routed to ch0 only (priority).
//  4 all ch addrs=0; send 07,FF -> drop pulse, no valids.
//    Next packet 04 with ch0_addr=0 is routed normally.
//  5 send 09, idle 3 cycles, A5, idle, 3C -> outputs track gaps, 3 bytes on ch1.
//    Change ch1_addr mid-packet -> no effect.
//  6 assert rst_n=0 after 09,A5 -> outputs 0, busy=0.
//    After release, 04 routes as a fresh len-1 packet.

Source files
------------

// File: rtl/packet_demux.sv
`default_nettype none
// ============================================================================
// Module      : packet_demux
// Description : Router input stage. Frames a byte-serial packet stream and
//               forwards each packet to the first channel whose address matches
//               the header destination; unmatched or oversize packets are dropped.
//               Optional CRC checking is enabled by defining CRC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module packet_demux #(
    parameter int MAX_LEN = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_en,
    input  logic [1:0] ch0_addr,
    input  logic [1:0] ch1_addr,
    input  logic [1:0] ch2_addr,
    input  logic       crc_en,
    output logic [7:0] ch0_dout,
    output logic       ch0_valid,
    output logic [7:0] ch1_dout,
    output logic       ch1_valid,
    output logic [7:0] ch2_dout,
    output logic       ch2_valid,
    output logic       busy,
    output logic       crc_err,
    output logic       drop
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_payload = 2'd1;
    localparam logic [1:0] c_st_crc     = 2'd2;
    localparam logic [1:0] c_st_drop    = 2'd3;
    localparam logic [6:0] c_max_len    = 7'(MAX_LEN);

    logic [1:0] r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic       r_crc_en, w_crc_en_nxt;

    logic [5:0] w_hdr_len;
    logic [1:0] w_hdr_dest;
    logic [1:0] w_hdr_sel;
    logic       w_hit;
    logic       w_route;
    logic       w_fwd;
    logic [1:0] w_fwd_ch;
    logic       w_drop;

    assign w_hdr_len  = din[7:2];
    assign w_hdr_dest = din[1:0];
    assign busy       = (r_state != c_st_idle);

    // Header decode: first matching channel wins, ch0 highest priority
    always_comb begin
        w_hdr_sel = 2'd0;
        w_hit     = 1'b1;
        if (w_hdr_dest == ch0_addr) begin
            w_hdr_sel = 2'd0;
        end else if (w_hdr_dest == ch1_addr) begin
            w_hdr_sel = 2'd1;
        end else if (w_hdr_dest == ch2_addr) begin
            w_hdr_sel = 2'd2;
        end else begin
            w_hit = 1'b0;
        end
        w_route = w_hit && ({1'b0, w_hdr_len} <= c_max_len);
    end

    // r_cnt holds payload bytes still expected; in DROP a zero count means
    // the next accepted byte is the trailing CRC
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_crc_en_nxt = r_crc_en;
        w_fwd        = 1'b0;
        w_fwd_ch     = r_sel;
        w_drop       = 1'b0;
        if (din_en) begin
            case (r_state)
                c_st_idle: begin
                    w_sel_nxt    = w_hdr_sel;
                    w_crc_en_nxt = crc_en;
                    w_cnt_nxt    = w_hdr_len;
                    if (w_route) begin
                        w_fwd    = 1'b1;
                        w_fwd_ch = w_hdr_sel;
                        if (w_hdr_len != 6'd0) begin
                            w_state_nxt = c_st_payload;
                        end else if (crc_en) begin
                            w_state_nxt = c_st_crc;
                        end
                    end else begin
                        w_drop = 1'b1;
                        if ((w_hdr_len != 6'd0) || crc_en) begin
                            w_state_nxt = c_st_drop;
                        end
                    end
                end
                c_st_payload: begin
                    w_fwd     = 1'b1;
                    w_cnt_nxt = r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        w_state_nxt = r_crc_en ? c_st_crc : c_st_idle;
                    end
                end
                c_st_crc: begin
                    w_fwd       = 1'b1;
                    w_state_nxt = c_st_idle;
                end
                c_st_drop: begin
                    if (r_cnt == 6'd0) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                        if ((r_cnt == 6'd1) && !r_crc_en) begin
                            w_state_nxt = c_st_idle;
                        end
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= 6'd0;
            r_sel     <= 2'd0;
            r_crc_en  <= 1'b0;
            ch0_dout  <= 8'd0;
            ch1_dout  <= 8'd0;
            ch2_dout  <= 8'd0;
            ch0_valid <= 1'b0;
            ch1_valid <= 1'b0;
            ch2_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
            r_crc_en  <= w_crc_en_nxt;
            ch0_valid <= w_fwd && (w_fwd_ch == 2'd0);
            ch1_valid <= w_fwd && (w_fwd_ch == 2'd1);
            ch2_valid <= w_fwd && (w_fwd_ch == 2'd2);
            if (w_fwd && (w_fwd_ch == 2'd0)) ch0_dout <= din;
            if (w_fwd && (w_fwd_ch == 2'd1)) ch1_dout <= din;
            if (w_fwd && (w_fwd_ch == 2'd2)) ch2_dout <= din;
            drop      <= w_drop;
        end
    end

`ifdef CRC_CHECK_EN
    logic [7:0] r_crc;
    logic       r_crc_err;
    logic       w_crc_byte;

    assign w_crc_byte = din_en && (r_state == c_st_crc);

    // Running XOR restarts on every header; dropped packets never reach CRC state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc     <= 8'd0;
            r_crc_err <= 1'b0;
        end else begin
            r_crc_err <= w_crc_byte && (din != r_crc);
            if (din_en) begin
                r_crc <= (r_state == c_st_idle) ? din : (r_crc ^ din);
            end
        end
    end

    assign crc_err = r_crc_err;
`else
    assign crc_err = 1'b0;
`endif

endmodule
`default_nettype wire
